// File: rtl/qspi_resp_pkg.sv
// Opcodes, phase lengths and state encoding shared by the QSPI PSRAM responder.
package qspi_resp_pkg;

   localparam logic [7:0] CMD_QREAD   = 8'hEB;
   localparam logic [7:0] CMD_QWRITE  = 8'h38;
   localparam logic [7:0] CMD_QPI_ON  = 8'h35;
   localparam logic [7:0] CMD_QPI_OFF = 8'hF5;

   localparam int ADDR_NIBBLES = 6;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      WAIT,
      RDATA,
      WDATA,
      IGNORE
   } state_t;

endpackage

// File: rtl/qspi_psram_responder_if.sv
// Serial bus between a QSPI initiator (master) and the PSRAM responder (slave).
interface qspi_psram_responder_if;

   logic       sck;
   logic       ce_n;
   logic [3:0] sio_i;
   logic [3:0] sio_o;
   logic [3:0] sio_oe;
   logic       busy;

   modport master (
      output sck, ce_n, sio_i,
      input  sio_o, sio_oe, busy
   );

   modport slave (
      input  sck, ce_n, sio_i,
      output sio_o, sio_oe, busy
   );

endinterface

// File: rtl/qspi_edge_sync.sv
// Two-flop synchronizers for sck, ce_n and sio plus one-cycle edge pulses.
module qspi_edge_sync (
   input  logic       clk,
   input  logic       rst,
   input  logic       sck,
   input  logic       ce_n,
   input  logic [3:0] sio_i,
   output logic [3:0] sio,
   output logic       sck_rise,
   output logic       sck_fall,
   output logic       ce_fall,
   output logic       ce_rise
);

   logic [2:0] sck_p;
   logic [2:0] ce_p;
   logic [3:0] sio_m;

   // Bit 1 is the synchronized value, bit 2 its one-cycle-old copy.
   always_ff @(posedge clk) begin
      if (rst) begin
         sck_p <= 3'b000;
         ce_p  <= 3'b111;
         sio_m <= 4'h0;
         sio   <= 4'h0;
      end else begin
         sck_p <= {sck_p[1:0], sck};
         ce_p  <= {ce_p[1:0], ce_n};
         sio_m <= sio_i;
         sio   <= sio_m;
      end
   end

   assign sck_rise = sck_p[1] & ~sck_p[2];
   assign sck_fall = ~sck_p[1] & sck_p[2];
   assign ce_fall  = ~ce_p[1] & ce_p[2];
   assign ce_rise  = ce_p[1] & ~ce_p[2];

endmodule

// File: rtl/qspi_psram_responder.sv
// Device-side QSPI PSRAM model: quad read/write against a byte array.
// Define QSPI_RESP_QPI_CMD_EN to enable the 0x35/0xF5 QPI mode commands.
module qspi_psram_responder
   import qspi_resp_pkg::*;
#(
   parameter int MEM_BYTES   = 65536,
   parameter int LATENCY     = 6,
   parameter int QPI_DEFAULT = 0
) (
   input logic                   clk,
   input logic                   rst,
   qspi_psram_responder_if.slave bus
);

   localparam int AW = $clog2(MEM_BYTES);

   state_t        state;
   state_t        state_nx;
   logic [3:0]    sio;
   logic          sck_rise;
   logic          sck_fall;
   logic          ce_fall;
   logic          ce_rise;
   logic [7:0]    cnt;
   logic [7:0]    cmd_sr;
   logic [7:0]    opcode;
   logic [AW-1:0] ptr;
   logic [3:0]    wnib;
   logic [3:0]    sio_o_q;
   logic [7:0]    rd_q;
   logic          half;
   logic          is_read;
   logic          qpi_mode;
   logic          cmd_done;
   logic          addr_done;
   logic          wait_done;
   logic          wr_step;
   logic          rd_step;
   logic          mem_we;
   logic [3:0]    sio_oe_c;
   logic          busy_c;

   logic [7:0] mem [MEM_BYTES];

   qspi_edge_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .sck      (bus.sck),
      .ce_n     (bus.ce_n),
      .sio_i    (bus.sio_i),
      .sio      (sio),
      .sck_rise (sck_rise),
      .sck_fall (sck_fall),
      .ce_fall  (ce_fall),
      .ce_rise  (ce_rise)
   );

`ifdef QSPI_RESP_QPI_CMD_EN
   logic qpi_q;
   logic pend_on;
   logic pend_off;

   // Mode switch is deferred to the end of the transaction that requested it.
   always_ff @(posedge clk) begin
      if (rst) begin
         qpi_q    <= (QPI_DEFAULT != 0);
         pend_on  <= 1'b0;
         pend_off <= 1'b0;
      end else if (ce_rise) begin
         if (pend_on)
            qpi_q <= 1'b1;
         else if (pend_off)
            qpi_q <= 1'b0;
         pend_on  <= 1'b0;
         pend_off <= 1'b0;
      end else if (state == CMD && sck_rise && cmd_done) begin
         pend_on  <= !qpi_q && (opcode == CMD_QPI_ON);
         pend_off <= qpi_q && (opcode == CMD_QPI_OFF);
      end
   end

   assign qpi_mode = qpi_q;
`else
   assign qpi_mode = (QPI_DEFAULT != 0);
`endif

   assign opcode    = qpi_mode ? {cmd_sr[3:0], sio} : {cmd_sr[6:0], sio[0]};
   assign cmd_done  = (cnt == (qpi_mode ? 8'd1 : 8'd7));
   assign addr_done = (cnt == 8'(ADDR_NIBBLES - 1));
   assign wait_done = (cnt == 8'(LATENCY));

   assign wr_step = (state == WDATA) && sck_rise && !ce_rise;
   assign rd_step = sck_fall && !ce_rise &&
                    ((state == RDATA) || (state == WAIT && wait_done));
   assign mem_we  = wr_step && half && !rst;

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (ce_rise) begin
         state_nx = IDLE;
      end else begin
         unique case (state)
            IDLE:
               if (ce_fall) state_nx = CMD;
            CMD:
               if (sck_rise && cmd_done)
                  state_nx = (opcode == CMD_QREAD || opcode == CMD_QWRITE) ?
                             ADDR : IGNORE;
            ADDR:
               if (sck_rise && addr_done)
                  state_nx = is_read ? WAIT : WDATA;
            WAIT:
               if (sck_fall && wait_done) state_nx = RDATA;
            default: ;
         endcase
      end
   end

   always_comb begin
      sio_oe_c = (state == RDATA) ? 4'hF : 4'h0;
      busy_c   = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= 8'd0;
         cmd_sr  <= 8'd0;
         ptr     <= '0;
         wnib    <= 4'h0;
         half    <= 1'b0;
         is_read <= 1'b0;
         sio_o_q <= 4'h0;
      end else begin
         if (state != state_nx)
            cnt <= 8'd0;
         else if (sck_rise)
            cnt <= cnt + 8'd1;
         if (state == CMD && sck_rise) begin
            cmd_sr  <= opcode;
            is_read <= (opcode == CMD_QREAD);
         end
         if (state == IDLE)
            half <= 1'b0;
         if (state == ADDR && sck_rise)
            ptr <= AW'({ptr, sio});
         if (wr_step) begin
            half <= ~half;
            wnib <= sio;
            if (half) ptr <= ptr + AW'(1);
         end
         // High nibble first; the pointer advances after the low nibble.
         if (rd_step) begin
            half    <= ~half;
            sio_o_q <= half ? rd_q[3:0] : rd_q[7:4];
            if (half) ptr <= ptr + AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[ptr] <= {wnib, sio};
      rd_q <= mem[ptr];
   end

   assign bus.sio_o  = sio_o_q;
   assign bus.sio_oe = sio_oe_c;
   assign bus.busy   = busy_c;

endmodule

// File: doc/qspi_psram_responder.md
# qspi_psram_responder

Synthesizable device-side model of the QSPI PSRAM that `qspi_if` drives. It decodes the chip-select, serial clock and SIO lanes in the system clock domain, executes quad read and quad write commands against an internal byte array, and returns read data after the configured latency. It is used in simulation benches and on FPGA loopback builds in place of an external PSRAM. Each responder instance attaches to one `ce_n` bit.

## Interface
- `MEM_BYTES`, 65536: size of the backing array in bytes; must be a power of two; addresses wrap modulo `MEM_BYTES`.
- `LATENCY`, 6: dummy sck cycles between the last address nibble and the first read-data nibble.
- `QPI_DEFAULT`, 0: value of quad-command mode after reset.
- `clk`  in  1  system clock; must be at least 4x the sck frequency.
- `rst`  in  1  synchronous reset, active-high.
- `sck`  in  1  serial clock from the initiator; asynchronous to `clk`.
- `ce_n`  in  1  chip select, active-low; asynchronous to `clk`.
- `sio_i`  in  4  SIO lanes as driven by the initiator.
- `sio_o`  out  4  SIO lanes driven by this responder.
- `sio_oe`  out  4  output enable per lane; the top level builds the inout.
- `busy`  out  1  high while a transaction is in progress (ce_n synchronized low).

## Operation
- `sck`, `ce_n` and `sio_i` pass through 2-flop synchronizers. Rising and falling sck edges are detected from the synchronized value.
- Input lanes are sampled on the detected sck rising edge. Output lanes change on the detected sck falling edge.
- Command phase: 8 bits, MSB first.
  - When `qpi_mode`=0, one bit per sck is taken from `sio_i[0]`.
  - When `qpi_mode`=1, one nibble per sck is taken from `sio_i[3:0]`.
- Commands:
  - 0xEB quad read: CMD → ADDR (6 nibbles, 24-bit address) → WAIT (`LATENCY` sck) → RDATA.
  - 0x38 quad write: CMD → ADDR → WDATA.
  - Any other opcode goes to IGNORE until ce_n rises.
- RDATA: each byte is sent as the high nibble then the low nibble. The address increments after each byte. `sio_oe`=4'hF only in RDATA.
- WDATA: each nibble pair is assembled into a byte, high nibble first. The byte is written to `mem[addr]` on the second nibble, then the address increments. A trailing half byte at ce_n rise is discarded.
- Address arithmetic uses the low log2(`MEM_BYTES`) bits only. The upper address bits are ignored. Incrementing past `MEM_BYTES`-1 wraps to 0.
- States: IDLE, CMD, ADDR, WAIT, RDATA, WDATA, IGNORE.
  - The synchronized ce_n going low moves IDLE → CMD and clears the bit counter.
  - The synchronized ce_n going high moves any state → IDLE. This takes priority over a simultaneous sck edge.
- Reset mid-transaction: returns to IDLE, clears `sio_oe`, and sets `qpi_mode`=`QPI_DEFAULT`. Memory contents are retained.

## Timing
- Reset values: `sio_o`=4'h0, `sio_oe`=4'h0, `busy`=0. Internally, state=IDLE and `qpi_mode`=`QPI_DEFAULT`.
- ce_n assert → `busy` high: 3 clk. ce_n deassert → `sio_oe`=0 and `busy` low: 3 clk.
- The first read nibble is driven on the falling sck edge that ends the last WAIT cycle, so it is valid for the initiator's next rising edge.
- The data path from sck edge to `sio_o` update is 3 clk (2 for synchronization, 1 registered).
- Writes commit to the array 1 clk after the detected rising edge that carries the low nibble.

## Configuration
- `QSPI_RESP_QPI_CMD_EN` defined:
  - Opcode 0x35 (in SPI mode) sets `qpi_mode`=1 when ce_n rises.
  - Opcode 0xF5 (in QPI mode) clears `qpi_mode` when ce_n rises.
- `QSPI_RESP_QPI_CMD_EN` undefined:
  - `qpi_mode` is the constant `QPI_DEFAULT`.
  - 0x35 and 0xF5 are treated as unknown opcodes (IGNORE).

## Structure
- Package `qspi_resp_pkg`:
  - opcode constants `CMD_QREAD`=8'hEB, `CMD_QWRITE`=8'h38, `CMD_QPI_ON`=8'h35, `CMD_QPI_OFF`=8'hF5;
  - the state enum;
  - `ADDR_NIBBLES`=6.
- Sub-module `qspi_edge_sync`: synchronizers for sck, ce_n and sio_i, plus single-cycle `sck_rise`, `sck_fall`, `ce_fall` and `ce_rise` pulses.
- The backing memory is a plain reg array inferred as block RAM.

## Test plan
- QPI mode, write 0x38 addr 0x000010 data 0xA5,0x3C; then read 0xEB addr 0x000010 with `LATENCY`=6 → nibbles A,5,3,C appear after exactly 6 dummy sck.
- Read burst at `MEM_BYTES`-1 with mem[last]=0x11 and mem[0]=0x22 → bytes 0x11, 0x22 (address wrap).
- Opcode 0x9F → `sio_oe` stays 0 for the whole transaction; the next valid command works normally.
- ce_n raised after 3 nibbles of write data → only the first byte is written; the byte at addr+1 is unchanged.
- `rst` pulsed during RDATA → `sio_oe`=0 on the next clk, state=IDLE, memory preserved on re-read.
- With `QSPI_RESP_QPI_CMD_EN` defined and `QPI_DEFAULT`=0:
  - 0x35 sent serially on sio[0] → the following 0xEB is accepted in nibble mode;
  - 0xF5 then restores serial command mode.
